// File: rtl/envelope_follower.sv
// Rectifying attack/release envelope follower with a registered, optionally velocity-scaled output.
// Optional feature macro: ENVELOPE_FOLLOWER_VELOCITY_EN (velocity multiplier; otherwise outSample = {env, 1'b0}).
module envelope_follower #(
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 6
) (
  input  logic        inClk,
  input  logic        inReset,
  input  logic [11:0] inSample,
  input  logic        inSampleReady,
  input  logic        inIsPlaying,
  input  logic [11:0] inVelocity,
  output logic [11:0] outSample,
  output logic        outSampleReady
);

  logic        ready_prev_q;
  logic        evt;
  logic        evt_q;
  logic [10:0] mag;
  logic [10:0] tgt;
  logic [10:0] env_q, env_d;
  logic [10:0] diff;
  logic [10:0] step;
  logic [11:0] out_q, out_d;
  logic        out_rdy_q;

  assign evt = inSampleReady & ~ready_prev_q;

  // Offset-binary to magnitude; the single code 0x000 would be 0x800 and saturates.
  always_comb begin
    mag = '0;
    if (inSample[11]) begin
      mag = inSample[10:0];
    end else if (inSample == 12'h000) begin
      mag = '1;
    end else begin
      mag = 11'(12'h800 - inSample);
    end
  end

  assign tgt = inIsPlaying ? mag : '0;

  // The step is at most the gap to the target, so env can never overshoot or wrap.
  always_comb begin
    env_d = env_q;
    diff  = '0;
    step  = '0;
    if (evt) begin
      if (tgt > env_q) begin
        diff  = tgt - env_q;
        step  = diff >> ATTACK_SHIFT;
        if (step == '0) step = 11'd1;
        env_d = env_q + step;
      end else if (tgt < env_q) begin
        diff  = env_q - tgt;
        step  = diff >> RELEASE_SHIFT;
        if (step == '0) step = 11'd1;
        env_d = env_q - step;
      end
    end
  end

`ifdef ENVELOPE_FOLLOWER_VELOCITY_EN
  logic [11:0] vel_q;
  logic [22:0] prod;

  // Velocity is captured with the event so later changes wait for the next event.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      vel_q <= '0;
    end else if (evt) begin
      vel_q <= inVelocity;
    end
  end

  always_comb begin
    prod  = 23'(env_q) * 23'(vel_q);
    out_d = prod[22:11];
  end
`else
  logic unused_velocity;

  assign unused_velocity = ^inVelocity;
  assign out_d           = {env_q, 1'b0};
`endif

  always_ff @(posedge inClk) begin
    if (inReset) begin
      ready_prev_q <= 1'b0;
      evt_q        <= 1'b0;
      env_q        <= '0;
      out_q        <= '0;
      out_rdy_q    <= 1'b0;
    end else begin
      ready_prev_q <= inSampleReady;
      evt_q        <= evt;
      env_q        <= env_d;
      out_rdy_q    <= evt_q;
      if (evt_q) out_q <= out_d;
    end
  end

  assign outSample      = out_q;
  assign outSampleReady = out_rdy_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Randomized bench for envelope_follower against an integer-arithmetic model, plus fixed expectations.
module tb_envelope_follower;

  localparam int AS = 2;
  localparam int RS = 6;

`ifdef ENVELOPE_FOLLOWER_VELOCITY_EN
  localparam int E_FIRST  = 23;
  localparam int E_SECOND = 41;
  localparam int E_CONV   = 95;
  localparam int E_CONVF  = 1533;
  localparam int E_DEC1   = 1511;
  localparam int E_SAT    = 12'hFFD;
`else
  localparam int E_FIRST  = 382;
  localparam int E_SECOND = 670;
  localparam int E_CONV   = 1534;
  localparam int E_CONVF  = 12'h5FE;
  localparam int E_DEC1   = 1512;
  localparam int E_SAT    = 12'hFFE;
`endif

  logic        inClk = 1'b0;
  logic        inReset = 1'b1;
  logic [11:0] inSample = 12'h800;
  logic        inSampleReady = 1'b0;
  logic        inIsPlaying = 1'b0;
  logic [11:0] inVelocity = '0;
  logic [11:0] outSample;
  logic        outSampleReady;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  bit checking = 1'b0;

  // Model state (plain integers, updated on each rising edge).
  int m_env = 0, m_prev = 0, m_pend = 0, m_pend_out = 0, m_out = 0, m_rdy = 0;

  envelope_follower #(.ATTACK_SHIFT(AS), .RELEASE_SHIFT(RS)) dut (
    .inClk(inClk), .inReset(inReset), .inSample(inSample), .inSampleReady(inSampleReady),
    .inIsPlaying(inIsPlaying), .inVelocity(inVelocity),
    .outSample(outSample), .outSampleReady(outSampleReady)
  );

  always #5 inClk = ~inClk;

  function automatic int rectify(int s);
    int m;
    m = (s >= 2048) ? s - 2048 : 2048 - s;
    return (m > 2047) ? 2047 : m;
  endfunction

  function automatic int next_env(int e, int t);
    int d;
    if (t > e) begin
      d = (t - e) / (1 << AS);
      return e + ((d == 0) ? 1 : d);
    end
    if (t < e) begin
      d = (e - t) / (1 << RS);
      return e - ((d == 0) ? 1 : d);
    end
    return e;
  endfunction

  function automatic int scale(int e, int v);
`ifdef ENVELOPE_FOLLOWER_VELOCITY_EN
    return (e * v) / 2048;
`else
    return e * 2 + (v * 0);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge inClk) begin
    if (inReset) begin
      m_env = 0; m_prev = 0; m_pend = 0; m_out = 0; m_rdy = 0;
    end else begin
      m_rdy = m_pend;
      if (m_pend != 0) m_out = m_pend_out;
      m_pend = 0;
      if (inSampleReady && m_prev == 0) begin
        m_env = next_env(m_env, inIsPlaying ? rectify(int'(inSample)) : 0);
        m_pend_out = scale(m_env, int'(inVelocity));
        m_pend = 1;
      end
      m_prev = int'(inSampleReady);
    end
  end

  always @(negedge inClk) begin
    if (checking) begin
      check("model_out", int'(outSample), m_out);
      check("model_rdy", int'(outSampleReady), m_rdy);
    end
    if (outSampleReady) pulses++;
  end

  task automatic tick();
    @(posedge inClk);
    #2;
  endtask

  // One event: high for one edge, low for one edge; afterwards the result is visible.
  task automatic do_event();
    inSampleReady = 1'b1;
    tick();
    inSampleReady = 1'b0;
    tick();
  endtask

  task automatic run_events(input int n);
    for (int i = 0; i < n; i++) do_event();
  endtask

  task automatic do_reset();
    inReset = 1'b1;
    tick();
    inReset = 1'b0;
  endtask

  initial begin
    int p0;
    tick();
    checking = 1'b1;
    check("reset_out", int'(outSample), 0);
    check("reset_rdy", int'(outSampleReady), 0);
    inReset = 1'b0;

    inSample = 12'hAFF; inVelocity = 12'h0FF; inIsPlaying = 1'b1;
    do_event();
    check("first_attack", int'(outSample), E_FIRST);
    check("first_pulse", int'(outSampleReady), 1);
    do_event();
    check("second_attack", int'(outSample), E_SECOND);
    p0 = pulses;
    tick();
    run_events(40);
    check("converged", int'(outSample), E_CONV);
    check("pulse_per_event", pulses - p0, 40);

    inVelocity = 12'hFFF;
    do_event();
    check("converged_fullvel", int'(outSample), E_CONVF);
    inIsPlaying = 1'b0;
    do_event();
    check("first_release", int'(outSample), E_DEC1);
    run_events(400);
    check("decayed_zero", int'(outSample), 0);

    inIsPlaying = 1'b1; inSample = 12'h000;
    run_events(400);
    check("saturated", int'(outSample), E_SAT);
    inSample = 12'h800;
    run_events(400);
    check("zero_level_decay", int'(outSample), 0);

    // Held-high strobe: a single event and a single pulse on the second edge.
    inSample = 12'hAFF;
    tick();
    p0 = pulses;
    inSampleReady = 1'b1;
    tick();
    check("held_edgeN", int'(outSampleReady), 0);
    tick();
    check("held_edgeN1", int'(outSampleReady), 1);
    tick();
    check("held_edgeN2", int'(outSampleReady), 0);
    repeat (7) tick();
    inSampleReady = 1'b0;
    repeat (2) tick();
    check("held_one_pulse", pulses - p0, 1);

    // Reset with env at 767 and a pulse pending.
    do_reset();
    inVelocity = 12'h0FF;
    run_events(40);
    check("pre_reset_conv", int'(outSample), E_CONV);
    inSampleReady = 1'b1;
    tick();
    inSampleReady = 1'b0;
    inReset = 1'b1;
    tick();
    check("reset_mid_out", int'(outSample), 0);
    check("reset_mid_rdy", int'(outSampleReady), 0);
    inReset = 1'b0;
    tick();
    check("reset_suppressed", int'(outSampleReady), 0);
    do_event();
    check("restart_attack", int'(outSample), E_FIRST);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      inSample    = 12'($urandom_range(0, 4095));
      inVelocity  = 12'($urandom_range(0, 4095));
      inIsPlaying = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) inReset = 1'b1;
      inSampleReady = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      inReset = 1'b0;
      inSampleReady = 1'b0;
      inSample    = 12'($urandom_range(0, 4095));
      inVelocity  = 12'($urandom_range(0, 4095));
      inIsPlaying = $urandom_range(0, 1) != 0;
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
